ps2_mole_input: RTL

- Upstream input stage of the mole game datapath; turns a PS/2 keyboard stream into the datapath's `userGameInput` hit code and `startGame` request.
- Deserialises 11-bit PS/2 frames and checks them. Tracks make/break (F0) prefixes and suppresses typematic repeats.
- Emits exactly one single-cycle hit pulse per physical key press, so the score increments once per press.

---
 rtl/ps2_mole_input_pkg.sv | 56 +++++
 rtl/ps2_mole_input_if.sv | 20 ++
 rtl/ps2_mole_input_ps2_rx.sv | 148 ++++++++++++++
 rtl/ps2_mole_input.sv | 86 ++++++++
 4 files changed

// File: rtl/ps2_mole_input_pkg.sv
// Shared constants for the mole-game PS/2 input stage: hit codes, scan codes,
// receiver FSM encoding and the key-map lookup used by the decoder.
package ps2_mole_input_pkg;

    // Hit codes presented to the game datapath
    localparam logic [2:0] HIT_NONE  = 3'b000;
    localparam logic [2:0] HIT_MOLE1 = 3'b001;
    localparam logic [2:0] HIT_MOLE2 = 3'b010;
    localparam logic [2:0] HIT_MOLE3 = 3'b011;
    localparam logic [2:0] HIT_MOLE4 = 3'b100;
    localparam logic [2:0] HIT_MOLE5 = 3'b101;

    // Set-2 scan codes the game cares about
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_F     = 8'h2B;
    localparam logic [7:0] SC_G     = 8'h34;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    // Slot numbers inside heldKeys; moles occupy 0..4
    localparam logic [2:0] SLOT_ENTER = 3'd5;

    // Frame receiver states, one PS/2 bit consumed per falling edge
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rxState_t;

    // Result of mapping a scan code onto a held-key slot
    typedef struct packed {
        logic       known;
        logic [2:0] slot;
    } keyLookup_t;

    function automatic keyLookup_t lookupKey(input logic [7:0] code);
        keyLookup_t result;
        result.known = 1'b1;
        result.slot  = 3'd0;
        case (code)
            SC_A:     result.slot = 3'd0;
            SC_S:     result.slot = 3'd1;
            SC_D:     result.slot = 3'd2;
            SC_F:     result.slot = 3'd3;
            SC_G:     result.slot = 3'd4;
            SC_ENTER: result.slot = SLOT_ENTER;
            default:  result.known = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/ps2_mole_input_if.sv
// Bundle between the PS/2 side plus the game datapath and the input stage.
// master = environment (drives the PS/2 lines), slave = ps2_mole_input.
interface ps2_mole_input_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [2:0] hit;
    logic       startGame;
    logic       frameError;
    logic [5:0] heldKeys;

    modport master (
        output ps2_clk, ps2_data,
        input  hit, startGame, frameError, heldKeys
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output hit, startGame, frameError, heldKeys
    );
endinterface

// File: rtl/ps2_mole_input_ps2_rx.sv
// PS/2 frame receiver: synchronises the raw lines, detects falling clock
// edges, deserialises start/8 data/odd parity/stop and abandons stalled frames.
module ps2_rx
    import ps2_mole_input_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [7:0] rxByte,
    output logic       byteValid,
    output logic       frameError
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clkSync;
    logic [SYNC_STAGES-1:0] dataSync;
    logic                   clkPrev;
    logic                   clkNow;
    logic                   dataNow;
    logic                   fallEdge;

    rxState_t      state, stateNext;
    logic [7:0]    shiftReg, shiftNext;
    logic [2:0]    bitCount, bitCountNext;
    logic          parityBit, parityNext;
    logic [TW-1:0] timeoutCount, timeoutNext;
    logic [7:0]    byteNext;
    logic          validNext;
    logic          errorNext;

    assign clkNow   = clkSync[SYNC_STAGES-1];
    assign dataNow  = dataSync[SYNC_STAGES-1];
    assign fallEdge = clkPrev & ~clkNow;

    // Synchronisers and edge history; idle bus level is 1
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clkSync  <= '1;
            dataSync <= '1;
            clkPrev  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so each stage samples its
            // predecessor's pre-edge value and the chain really delays.
            clkSync  <= {clkSync[SYNC_STAGES-2:0], ps2Clk};
            dataSync <= {dataSync[SYNC_STAGES-2:0], ps2Data};
            clkPrev  <= clkNow;
        end
    end

    // State register plus frame datapath and the registered result pulses
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= RX_IDLE;
            shiftReg     <= '0;
            bitCount     <= '0;
            parityBit    <= 1'b0;
            timeoutCount <= '0;
            rxByte       <= '0;
            byteValid    <= 1'b0;
            frameError   <= 1'b0;
        end else begin
            state        <= stateNext;
            shiftReg     <= shiftNext;
            bitCount     <= bitCountNext;
            parityBit    <= parityNext;
            timeoutCount <= timeoutNext;
            rxByte       <= byteNext;
            byteValid    <= validNext;
            frameError   <= errorNext;
        end
    end

    // Next-state logic: one frame bit per falling edge, timeout overrides
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned and infers a latch.
        stateNext    = state;
        shiftNext    = shiftReg;
        bitCountNext = bitCount;
        parityNext   = parityBit;
        timeoutNext  = timeoutCount;
        byteNext     = rxByte;
        validNext    = 1'b0;
        errorNext    = 1'b0;

        case (state)
            RX_IDLE: begin
                timeoutNext = '0;
                if (fallEdge) begin
                    if (!dataNow) begin
                        stateNext    = RX_DATA;
                        bitCountNext = '0;
                    end else begin
                        errorNext = 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (fallEdge) begin
                    shiftNext = {dataNow, shiftReg[7:1]};
                    if (bitCount == 3'd7) begin
                        stateNext = RX_PARITY;
                    end else begin
                        bitCountNext = bitCount + 3'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (fallEdge) begin
                    parityNext = dataNow;
                    stateNext  = RX_STOP;
                end
            end
            RX_STOP: begin
                if (fallEdge) begin
                    if (dataNow && (^{shiftReg, parityBit})) begin
                        validNext = 1'b1;
                        byteNext  = shiftReg;
                    end else begin
                        errorNext = 1'b1;
                    end
                    stateNext = RX_IDLE;
                end
            end
            default: stateNext = RX_IDLE;
        endcase

        // A live edge keeps the frame alive; silence past the limit drops it
        if (state != RX_IDLE) begin
            if (fallEdge) begin
                timeoutNext = '0;
            end else if (timeoutCount == TIMEOUT_LAST) begin
                timeoutNext = '0;
                errorNext   = 1'b1;
                stateNext   = RX_IDLE;
            end else begin
                timeoutNext = timeoutCount + TW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_mole_input.sv
// Mole game input stage: receives PS/2 bytes, tracks E0/F0 prefixes, keeps
// the held-key map and emits one pulse per physical press.
module ps2_mole_input
    import ps2_mole_input_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             clock,
    input  logic             reset,
    ps2_mole_input_if.slave  bus
);

    logic [7:0] rxByte;
    logic       byteValid;
    logic       rxError;

    logic       breakPending;
    logic       extPending;
    logic [5:0] heldReg;
    logic [2:0] hitReg;
    logic       startReg;
    keyLookup_t key;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_rx (
        .clock      (clock),
        .reset      (reset),
        .ps2Clk     (bus.ps2_clk),
        .ps2Data    (bus.ps2_data),
        .rxByte     (rxByte),
        .byteValid  (byteValid),
        .frameError (rxError)
    );

    assign key = lookupKey(rxByte);

    // Decoder: prefix flags, held-key map and single-cycle press pulses
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            breakPending <= 1'b0;
            extPending   <= 1'b0;
            heldReg      <= '0;
            hitReg       <= HIT_NONE;
            startReg     <= 1'b0;
        end else begin
            hitReg   <= HIT_NONE;
            startReg <= 1'b0;
            if (rxError) begin
                // A broken frame may have eaten the byte a prefix belonged to
                breakPending <= 1'b0;
                extPending   <= 1'b0;
            end else if (byteValid) begin
                if (rxByte == SC_EXT) begin
                    extPending <= 1'b1;
                end else if (rxByte == SC_BREAK) begin
                    breakPending <= 1'b1;
                end else begin
                    breakPending <= 1'b0;
                    extPending   <= 1'b0;
                    if (!extPending && key.known) begin
                        if (breakPending) begin
                            heldReg[key.slot] <= 1'b0;
                        end else if (!heldReg[key.slot]) begin
                            // First make only; typematic repeats find the bit set
                            heldReg[key.slot] <= 1'b1;
                            if (key.slot == SLOT_ENTER) begin
                                startReg <= 1'b1;
                            end else begin
                                hitReg <= key.slot + 3'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    assign bus.hit        = hitReg;
    assign bus.startGame  = startReg;
    assign bus.frameError = rxError;
    assign bus.heldKeys   = heldReg;

endmodule
